// File: rtl/riscv_defines.sv
// Types shared between the hazard tracker (initiator) and hazard_unit (target).
package riscv_defines;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } memaccess_t;

    typedef enum logic [1:0] {
        CF_NONE   = 2'd0,
        CF_BRANCH = 2'd1,
        CF_JAL    = 2'd2,
        CF_JALR   = 2'd3
    } cflow_mode_t;

    typedef struct packed {
        logic load_use;
        logic branch_mispredict;
    } hazard_cause_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        memaccess_t       memaccess;
        cflow_mode_t      cflow_mode;
    } stage_meta_t;

    localparam stage_meta_t STAGE_BUBBLE = '{
        valid:      1'b0,
        rs1:        '0,
        rs2:        '0,
        rd:         '0,
        regwrite:   1'b0,
        memaccess:  MEM_NONE,
        cflow_mode: CF_NONE
    };

    typedef struct packed {
        logic [REG_W-1:0] rs1_d;
        logic [REG_W-1:0] rs2_d;
        logic [REG_W-1:0] rs1_e;
        logic [REG_W-1:0] rs2_e;
        logic [REG_W-1:0] rd_e;
        logic             regwrite_e;
        memaccess_t       memaccess_e;
        logic [REG_W-1:0] rs1_m;
        logic [REG_W-1:0] rs2_m;
        logic [REG_W-1:0] rd_m;
        logic             regwrite_m;
        memaccess_t       memaccess_m;
        cflow_mode_t      cflow_mode_m;
        logic [REG_W-1:0] rs1_w;
        logic [REG_W-1:0] rs2_w;
        logic [REG_W-1:0] rd_w;
        logic             regwrite_w;
        memaccess_t       memaccess_w;
        cflow_mode_t      cflow_mode_w;
        cflow_mode_t      cflow_mode;
        logic             mispredict;
        logic             flushflag;
    } hazard_req_t;

    typedef struct packed {
        logic          stall_f;
        logic          stall_d;
        logic          flush_d;
        logic          flush_e;
        logic          flush_m;
        hazard_cause_t hazard_cause;
    } hazard_res_t;

    // A record only claims a register write while it holds a real instruction.
    function automatic logic live_regwrite(input stage_meta_t s);
        return s.valid & s.regwrite;
    endfunction

endpackage

// File: rtl/hazard_interface.sv
// Request/response bundle between the hazard tracker and hazard_unit.
interface hazard_interface;
    import riscv_defines::*;

    hazard_req_t req;
    hazard_res_t res;

    modport initiator (output req, input res);
    modport target    (input req, output res);
endinterface

// File: rtl/hazard_perf_counters.sv
// Five free-running hazard event counters, wrapping modulo 2^CNT_W.
module hazard_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ev_stall,
    input  logic             ev_load_use,
    input  logic             ev_mispredict,
    input  logic             ev_flush,
    output logic [CNT_W-1:0] cnt_cycle,
    output logic [CNT_W-1:0] cnt_stall,
    output logic [CNT_W-1:0] cnt_load_use,
    output logic [CNT_W-1:0] cnt_mispredict,
    output logic [CNT_W-1:0] cnt_flush
);

    logic [CNT_W-1:0] cnt_cycle_q, cnt_cycle_d;
    logic [CNT_W-1:0] cnt_stall_q, cnt_stall_d;
    logic [CNT_W-1:0] cnt_load_use_q, cnt_load_use_d;
    logic [CNT_W-1:0] cnt_mispredict_q, cnt_mispredict_d;
    logic [CNT_W-1:0] cnt_flush_q, cnt_flush_d;

    always_comb begin
        cnt_cycle_d      = cnt_cycle_q + CNT_W'(1);
        cnt_stall_d      = cnt_stall_q + CNT_W'(ev_stall);
        cnt_load_use_d   = cnt_load_use_q + CNT_W'(ev_load_use);
        cnt_mispredict_d = cnt_mispredict_q + CNT_W'(ev_mispredict);
        cnt_flush_d      = cnt_flush_q + CNT_W'(ev_flush);
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_cycle_q      <= '0;
            cnt_stall_q      <= '0;
            cnt_load_use_q   <= '0;
            cnt_mispredict_q <= '0;
            cnt_flush_q      <= '0;
        end else begin
            cnt_cycle_q      <= cnt_cycle_d;
            cnt_stall_q      <= cnt_stall_d;
            cnt_load_use_q   <= cnt_load_use_d;
            cnt_mispredict_q <= cnt_mispredict_d;
            cnt_flush_q      <= cnt_flush_d;
        end
    end

    assign cnt_cycle      = cnt_cycle_q;
    assign cnt_stall      = cnt_stall_q;
    assign cnt_load_use   = cnt_load_use_q;
    assign cnt_mispredict = cnt_mispredict_q;
    assign cnt_flush      = cnt_flush_q;

endmodule

// File: rtl/hazard_tracker.sv
// Tracks E/M/W hazard metadata, drives hazard_bus.req and converts the
// stall/flush response into pipeline-register enables and clears.
module hazard_tracker
    import riscv_defines::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hazard_interface.initiator   hazard_bus,
    input  logic                 valid_d,
    input  logic [REG_W-1:0]     rs1_d,
    input  logic [REG_W-1:0]     rs2_d,
    input  logic [REG_W-1:0]     rd_d,
    input  logic                 regwrite_d,
    input  memaccess_t           memaccess_d,
    input  cflow_mode_t          cflow_mode_d,
    input  logic                 mispredict_e,
    input  logic                 trap_flush,
    output logic                 en_f,
    output logic                 en_d,
    output logic                 clr_d,
    output logic                 clr_e,
    output logic                 clr_m,
    output logic                 valid_e,
    output logic                 valid_m,
    output logic                 valid_w,
    output logic [CNT_W-1:0]     cnt_cycle,
    output logic [CNT_W-1:0]     cnt_stall,
    output logic [CNT_W-1:0]     cnt_load_use,
    output logic [CNT_W-1:0]     cnt_mispredict,
    output logic [CNT_W-1:0]     cnt_flush
);

    stage_meta_t rec_e_q, rec_e_d;
    stage_meta_t rec_m_q, rec_m_d;
    stage_meta_t rec_w_q, rec_w_d;
    hazard_res_t res;
    hazard_req_t req;

    assign res = hazard_bus.res;

    // Flush wins over stall; a stalled D is replaced by a bubble so it is not issued twice.
    always_comb begin
        rec_w_d = rec_m_q;
        rec_m_d = res.flush_m ? STAGE_BUBBLE : rec_e_q;
        if (res.flush_e || res.stall_d) begin
            rec_e_d = STAGE_BUBBLE;
        end else begin
            rec_e_d = '{
                valid:      valid_d,
                rs1:        rs1_d,
                rs2:        rs2_d,
                rd:         rd_d,
                regwrite:   regwrite_d,
                memaccess:  memaccess_d,
                cflow_mode: cflow_mode_d
            };
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec_e_q <= STAGE_BUBBLE;
            rec_m_q <= STAGE_BUBBLE;
            rec_w_q <= STAGE_BUBBLE;
        end else begin
            rec_e_q <= rec_e_d;
            rec_m_q <= rec_m_d;
            rec_w_q <= rec_w_d;
        end
    end

    // NOTE: every field gets a default first so no path through this block infers a latch.
    always_comb begin
        req              = '0;
        req.rs1_d        = valid_d ? rs1_d : '0;
        req.rs2_d        = valid_d ? rs2_d : '0;
        req.rs1_e        = rec_e_q.rs1;
        req.rs2_e        = rec_e_q.rs2;
        req.rd_e         = rec_e_q.rd;
        req.regwrite_e   = live_regwrite(rec_e_q);
        req.memaccess_e  = rec_e_q.memaccess;
        req.rs1_m        = rec_m_q.rs1;
        req.rs2_m        = rec_m_q.rs2;
        req.rd_m         = rec_m_q.rd;
        req.regwrite_m   = live_regwrite(rec_m_q);
        req.memaccess_m  = rec_m_q.memaccess;
        req.cflow_mode_m = rec_m_q.cflow_mode;
        req.rs1_w        = rec_w_q.rs1;
        req.rs2_w        = rec_w_q.rs2;
        req.rd_w         = rec_w_q.rd;
        req.regwrite_w   = live_regwrite(rec_w_q);
        req.memaccess_w  = rec_w_q.memaccess;
        req.cflow_mode_w = rec_w_q.cflow_mode;
        req.cflow_mode   = rec_e_q.cflow_mode;
        req.mispredict   = mispredict_e & rec_e_q.valid;
        req.flushflag    = trap_flush;
    end

    assign hazard_bus.req = req;

    assign en_f    = !res.stall_f;
    assign en_d    = !res.stall_d;
    assign clr_d   = res.flush_d;
    assign clr_e   = res.flush_e;
    assign clr_m   = res.flush_m;
    assign valid_e = rec_e_q.valid;
    assign valid_m = rec_m_q.valid;
    assign valid_w = rec_w_q.valid;

    hazard_perf_counters #(.CNT_W(CNT_W)) u_perf (
        .clk            (clk),
        .rst_n          (rst_n),
        .ev_stall       (res.stall_d),
        .ev_load_use    (res.hazard_cause.load_use),
        .ev_mispredict  (res.hazard_cause.branch_mispredict),
        .ev_flush       (trap_flush),
        .cnt_cycle      (cnt_cycle),
        .cnt_stall      (cnt_stall),
        .cnt_load_use   (cnt_load_use),
        .cnt_mispredict (cnt_mispredict),
        .cnt_flush      (cnt_flush)
    );

endmodule

// File: tb/tb_hazard_tracker.sv
// Self-checking bench: the bench plays hazard_unit and compares the tracker
// against a queue-of-stages reference model.
module tb_hazard_tracker;
    import riscv_defines::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        valid_d, regwrite_d, mispredict_e, trap_flush;
    logic [4:0]  rs1_d, rs2_d, rd_d;
    memaccess_t  memaccess_d;
    cflow_mode_t cflow_mode_d;
    hazard_res_t res_in;

    logic        en_f, en_d, clr_d, clr_e, clr_m, valid_e, valid_m, valid_w;
    logic [31:0] cnt_cycle, cnt_stall, cnt_load_use, cnt_mispredict, cnt_flush;

    logic        en_f4, en_d4, clr_d4, clr_e4, clr_m4, valid_e4, valid_m4, valid_w4;
    logic [3:0]  cyc4, stall4, lu4, mp4, fl4;

    hazard_interface hz ();
    hazard_interface hz4 ();
    assign hz.res  = res_in;
    assign hz4.res = '0;

    hazard_tracker #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .hazard_bus(hz),
        .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .regwrite_d(regwrite_d), .memaccess_d(memaccess_d), .cflow_mode_d(cflow_mode_d),
        .mispredict_e(mispredict_e), .trap_flush(trap_flush),
        .en_f(en_f), .en_d(en_d), .clr_d(clr_d), .clr_e(clr_e), .clr_m(clr_m),
        .valid_e(valid_e), .valid_m(valid_m), .valid_w(valid_w),
        .cnt_cycle(cnt_cycle), .cnt_stall(cnt_stall), .cnt_load_use(cnt_load_use),
        .cnt_mispredict(cnt_mispredict), .cnt_flush(cnt_flush)
    );

    hazard_tracker #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .hazard_bus(hz4),
        .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .regwrite_d(regwrite_d), .memaccess_d(memaccess_d), .cflow_mode_d(cflow_mode_d),
        .mispredict_e(mispredict_e), .trap_flush(trap_flush),
        .en_f(en_f4), .en_d(en_d4), .clr_d(clr_d4), .clr_e(clr_e4), .clr_m(clr_m4),
        .valid_e(valid_e4), .valid_m(valid_m4), .valid_w(valid_w4),
        .cnt_cycle(cyc4), .cnt_stall(stall4), .cnt_load_use(lu4),
        .cnt_mispredict(mp4), .cnt_flush(fl4)
    );

    // Reference model: pipe[0]=E, pipe[1]=M, pipe[2]=W.
    typedef struct {
        bit       v;
        bit [4:0] rs1, rs2, rd;
        bit       rw;
        int       mem;
        int       cf;
    } rec_t;

    rec_t        pipe [3];
    logic [31:0] m_cycle, m_stall, m_lu, m_mp, m_fl;
    logic [3:0]  m_cycle4;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic rec_t bubble();
        rec_t b;
        b = '{default: 0};
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = bubble();
        m_cycle = 0; m_stall = 0; m_lu = 0; m_mp = 0; m_fl = 0; m_cycle4 = 0;
    endtask

    task automatic model_tick();
        rec_t incoming;
        incoming = '{v: valid_d, rs1: rs1_d, rs2: rs2_d, rd: rd_d, rw: regwrite_d,
                     mem: int'(memaccess_d), cf: int'(cflow_mode_d)};
        if (res_in.flush_e || res_in.stall_d) incoming = bubble();
        pipe[2] = pipe[1];
        pipe[1] = res_in.flush_m ? bubble() : pipe[0];
        pipe[0] = incoming;
        m_cycle  = m_cycle + 1;
        m_cycle4 = m_cycle4 + 1;
        if (res_in.stall_d) m_stall = m_stall + 1;
        if (res_in.hazard_cause.load_use) m_lu = m_lu + 1;
        if (res_in.hazard_cause.branch_mispredict) m_mp = m_mp + 1;
        if (trap_flush) m_fl = m_fl + 1;
    endtask

    task automatic check_all();
        check("valid_e", valid_e, pipe[0].v);
        check("valid_m", valid_m, pipe[1].v);
        check("valid_w", valid_w, pipe[2].v);
        check("en_f", en_f, !res_in.stall_f);
        check("en_d", en_d, !res_in.stall_d);
        check("clr_d", clr_d, res_in.flush_d);
        check("clr_e", clr_e, res_in.flush_e);
        check("clr_m", clr_m, res_in.flush_m);
        check("req.rs1_d", hz.req.rs1_d, valid_d ? rs1_d : 5'd0);
        check("req.rs2_d", hz.req.rs2_d, valid_d ? rs2_d : 5'd0);
        check("req.rs1_e", hz.req.rs1_e, pipe[0].rs1);
        check("req.rs2_e", hz.req.rs2_e, pipe[0].rs2);
        check("req.rd_e", hz.req.rd_e, pipe[0].rd);
        check("req.regwrite_e", hz.req.regwrite_e, pipe[0].v & pipe[0].rw);
        check("req.memaccess_e", hz.req.memaccess_e, pipe[0].mem);
        check("req.rs1_m", hz.req.rs1_m, pipe[1].rs1);
        check("req.rs2_m", hz.req.rs2_m, pipe[1].rs2);
        check("req.rd_m", hz.req.rd_m, pipe[1].rd);
        check("req.regwrite_m", hz.req.regwrite_m, pipe[1].v & pipe[1].rw);
        check("req.memaccess_m", hz.req.memaccess_m, pipe[1].mem);
        check("req.cflow_mode_m", hz.req.cflow_mode_m, pipe[1].cf);
        check("req.rs1_w", hz.req.rs1_w, pipe[2].rs1);
        check("req.rs2_w", hz.req.rs2_w, pipe[2].rs2);
        check("req.rd_w", hz.req.rd_w, pipe[2].rd);
        check("req.regwrite_w", hz.req.regwrite_w, pipe[2].v & pipe[2].rw);
        check("req.memaccess_w", hz.req.memaccess_w, pipe[2].mem);
        check("req.cflow_mode_w", hz.req.cflow_mode_w, pipe[2].cf);
        check("req.cflow_mode", hz.req.cflow_mode, pipe[0].cf);
        check("req.mispredict", hz.req.mispredict, mispredict_e & pipe[0].v);
        check("req.flushflag", hz.req.flushflag, trap_flush);
        check("cnt_cycle", cnt_cycle, m_cycle);
        check("cnt_stall", cnt_stall, m_stall);
        check("cnt_load_use", cnt_load_use, m_lu);
        check("cnt_mispredict", cnt_mispredict, m_mp);
        check("cnt_flush", cnt_flush, m_fl);
        check("cnt_cycle_w4", cyc4, m_cycle4);
    endtask

    task automatic set_d(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic rw, input memaccess_t mem);
        valid_d = v; rs1_d = r1; rs2_d = r2; rd_d = rd; regwrite_d = rw;
        memaccess_d = mem; cflow_mode_d = CF_NONE;
    endtask

    task automatic idle();
        set_d(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, MEM_NONE);
        mispredict_e = 1'b0; trap_flush = 1'b0; res_in = '0;
    endtask

    task automatic settle();
        #1;
        check_all();
    endtask

    task automatic adv();
        @(posedge clk);
        model_tick();
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic old_mv;
        rst_n = 1'b0;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        settle();
        rst_n = 1'b1;
        adv();

        // Load-use: load rd=5 enters E, dependent rs1=5 waits in D.
        set_d(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, MEM_LOAD);
        settle(); adv();
        set_d(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, MEM_NONE);
        res_in = '0;
        res_in.stall_f = 1'b1; res_in.stall_d = 1'b1; res_in.flush_e = 1'b1;
        res_in.hazard_cause.load_use = 1'b1;
        settle();
        check("lu_en_f", en_f, 1'b0);
        check("lu_en_d", en_d, 1'b0);
        check("lu_clr_e", clr_e, 1'b1);
        adv();
        res_in = '0;
        settle();
        check("lu_bubble_e", valid_e, 1'b0);
        check("lu_load_in_m", hz.req.rd_m, 5'd5);
        check("lu_en_f_release", en_f, 1'b1);
        check("lu_cnt_stall", cnt_stall, 32'd1);
        check("lu_cnt_load_use", cnt_load_use, 32'd1);
        adv();
        idle();
        settle();
        check("lu_dep_in_e", hz.req.rs1_e, 5'd5);
        check("lu_dep_valid_e", valid_e, 1'b1);

        // Mispredict with a valid E instruction: the bench acts as hazard_unit.
        set_d(1'b1, 5'd3, 5'd4, 5'd9, 1'b1, MEM_NONE);
        mispredict_e = 1'b1;
        res_in.flush_d = 1'b1; res_in.flush_e = 1'b1;
        res_in.hazard_cause.branch_mispredict = 1'b1;
        settle();
        check("mp_req", hz.req.mispredict, 1'b1);
        check("mp_clr_d", clr_d, 1'b1);
        adv();
        idle();
        settle();
        check("mp_clr_d_one_cycle", clr_d, 1'b0);
        check("mp_cnt", cnt_mispredict, 32'd1);
        check("mp_e_flushed", valid_e, 1'b0);
        adv();
        // Mispredict while E holds a bubble: no request, no flush.
        mispredict_e = 1'b1;
        settle();
        check("mp_invalid_req", hz.req.mispredict, 1'b0);
        adv();
        idle();
        settle();
        check("mp_invalid_cnt", cnt_mispredict, 32'd1);

        // Trap flush in the same cycle as a load-use stall.
        set_d(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, MEM_NONE);
        settle(); adv();
        set_d(1'b1, 5'd0, 5'd0, 5'd2, 1'b1, MEM_LOAD);
        settle(); adv();
        set_d(1'b1, 5'd2, 5'd0, 5'd3, 1'b1, MEM_NONE);
        trap_flush = 1'b1;
        res_in = '0;
        res_in.stall_f = 1'b1; res_in.stall_d = 1'b1;
        res_in.flush_d = 1'b1; res_in.flush_e = 1'b1; res_in.flush_m = 1'b1;
        res_in.hazard_cause.load_use = 1'b1;
        old_mv = pipe[1].v;
        settle();
        check("trap_clr_d", clr_d, 1'b1);
        check("trap_clr_e", clr_e, 1'b1);
        check("trap_clr_m", clr_m, 1'b1);
        adv();
        idle();
        settle();
        check("trap_valid_e", valid_e, 1'b0);
        check("trap_valid_m", valid_m, 1'b0);
        check("trap_valid_w", valid_w, old_mv);
        check("trap_cnt_flush", cnt_flush, 32'd1);
        adv();

        // Invalid M record with rd=7 and regwrite must not claim a write.
        set_d(1'b0, 5'd0, 5'd0, 5'd7, 1'b1, MEM_NONE);
        settle(); adv();
        idle();
        settle(); adv();
        settle();
        check("fwd_rd_m", hz.req.rd_m, 5'd7);
        check("fwd_regwrite_m", hz.req.regwrite_m, 1'b0);
        adv();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            set_d(1'($urandom_range(0, 3) != 0), 5'($urandom), 5'($urandom), 5'($urandom),
                  1'($urandom), memaccess_t'($urandom_range(0, 2)));
            cflow_mode_d = cflow_mode_t'($urandom_range(0, 3));
            mispredict_e = ($urandom_range(0, 9) == 0);
            trap_flush   = ($urandom_range(0, 11) == 0);
            res_in = '0;
            res_in.stall_d = ($urandom_range(0, 5) == 0);
            res_in.stall_f = res_in.stall_d | ($urandom_range(0, 15) == 0);
            res_in.flush_d = ($urandom_range(0, 7) == 0);
            res_in.flush_e = ($urandom_range(0, 7) == 0);
            res_in.flush_m = ($urandom_range(0, 9) == 0);
            res_in.hazard_cause.load_use          = ($urandom_range(0, 7) == 0);
            res_in.hazard_cause.branch_mispredict = ($urandom_range(0, 7) == 0);
            settle();
            adv();
        end

        // Fill the pipe, then reset mid-stream.
        for (int n = 0; n < 3; n++) begin
            set_d(1'b1, 5'd1, 5'd2, 5'(n + 10), 1'b1, MEM_NONE);
            mispredict_e = 1'b0; trap_flush = 1'b0; res_in = '0;
            settle(); adv();
        end
        idle();
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all();
        check("rst_valid_w", valid_w, 1'b0);
        check("rst_cnt_cycle", cnt_cycle, 32'd0);
        check("rst_en_f", en_f, 1'b1);
        check("rst_clr_e", clr_e, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // 17 cycles on the 4-bit instance wraps the cycle counter to 1.
        for (int n = 0; n < 17; n++) begin
            settle();
            adv();
        end
        settle();
        check("wrap_cnt_cycle_w4", cyc4, 4'd1);
        check("wrap_cnt_cycle_w32", cnt_cycle, 32'd17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
